timer8_core: RTL and testbench
==============================

TIMER8_CORE -- requirements
Module: timer8_core

Interface
REQ-001 SHALL have parameter OCR_RESET, default 8'hFF, reset value of the OCR register.
REQ-002 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have ports tick8, tick64, tick256, tick1024, input, 1 each: single-cycle prescaler pulses (clock/8, /64, /256, /1024).
REQ-005 SHALL have port wr_en, input, 1: register write strobe, one write per asserted cycle.
REQ-006 SHALL have port addr, input, 2: register select (0 TCNT, 1 OCR, 2 CTRL, 3 FLAGS).
REQ-007 SHALL have port wdata, input, 8: write data.
REQ-008 SHALL have port rdata, output, 8: combinational read of the register selected by addr.
REQ-009 SHALL have port irq, output, 1: (TOV & TOIE) | (OCF & OCIE), combinational from registers.
REQ-010 SHALL have port oc, output, 1: registered PWM compare output.

Function
REQ-011 CTRL bits SHALL be: [2:0] CS, [3] CTC, [4] TOIE, [5] PWM, [6] OCIE, [7] reserved (reads 0).
REQ-012 Count enable SHALL be selected by CS: 0 stopped, 1 every clock, 2 tick8, 3 tick64, 4 tick256, 5 tick1024, 6/7 stopped.
REQ-013 On count enable with CTC=0, TCNT SHALL increment by 1, wrapping 8'hFF -> 8'h00.
REQ-014 On count enable with TCNT==8'hFF, TOV (FLAGS[0]) SHALL be set on the same edge TCNT updates.
REQ-015 On count enable with TCNT==OCR, OCF (FLAGS[1]) SHALL be set on the same edge.
REQ-016 On count enable with CTC=1 and TCNT==OCR, TCNT SHALL load 8'h00 instead of incrementing.
REQ-017 CTC=1 with OCR==8'hFF SHALL set both TOV and OCF on the clear edge.
REQ-018 Count-enable cycles with CS selecting a tick not asserted that cycle SHALL leave TCNT and flags unchanged.
REQ-019 Write to TCNT in a count-enable cycle SHALL win: TCNT takes wdata, no increment, no flag set that cycle.
REQ-020 Write to OCR SHALL take effect on the next edge; compare in the write cycle uses the old OCR.
REQ-021 FLAGS SHALL be write-1-to-clear per bit; writing 0 leaves the bit unchanged; FLAGS[7:2] read 0.
REQ-022 A hardware flag set and a W1C clear of the same bit in the same cycle SHALL leave the bit set.
REQ-023 Changing CS SHALL take effect on the next cycle; TCNT SHALL NOT be cleared by CS changes.
REQ-024 irq SHALL remain asserted while any enabled flag is set (level, not pulse).

Reset
REQ-025 Reset SHALL set TCNT=8'h00, OCR=OCR_RESET, CTRL=8'h00, FLAGS=8'h00, oc=0.
REQ-026 Reset SHALL take priority over register writes and count enable in the same cycle, including mid-count.
REQ-027 irq SHALL be 0 and rdata SHALL reflect reset values in the cycle after reset.

Configuration
REQ-028 Macro TIMER8_PWM_EN defined: each edge oc <= PWM & (TCNT < OCR), computed from pre-edge values.
REQ-029 With TIMER8_PWM_EN: OCR=8'h00 gives oc=0 constantly; OCR=8'hFF gives oc=1 except after TCNT=8'hFF.
REQ-030 Without TIMER8_PWM_EN: oc SHALL be constant 0, CTRL[5] SHALL not store and SHALL read 0.

Verification
REQ-031 CS=1, CTC=0, TCNT written 8'hFD: after 3 clocks TCNT=8'h00, TOV=1; with TOIE=1, irq=1.
REQ-032 CS=3, tick64 pulsed once every 64 clocks: TCNT advances by exactly 1 per pulse; tick8 pulses ignored.
REQ-033 CS=1, CTC=1, OCR=8'h04 from TCNT=0: TCNT sequence 0,1,2,3,4,0,1...; OCF sets on 4->0 edge; TOV stays 0.
REQ-034 OCF set; write FLAGS=8'h02 in a cycle also producing a new match -> OCF remains 1; next write 8'h02 with no match -> OCF=0.
REQ-035 CS=1, write TCNT=8'h10 in a count-enable cycle -> TCNT=8'h10 next cycle, not 8'h11; assert reset mid-count -> all registers reset values next cycle.
REQ-036 TIMER8_PWM_EN, PWM=1, CS=1, OCR=8'h40: oc high 64 of every 256 clocks; without macro oc=0 and CTRL reads bit5=0.

Source files
------------

// File: rtl/timer8_core.sv
// timer8_core: 8-bit timer/counter with prescaled count enable, compare match, CTC and flags.
// Optional PWM compare output on oc is built only when TIMER8_PWM_EN is defined.
module timer8_core #(
  parameter logic [7:0] OCR_RESET = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick8,
  input  logic       tick64,
  input  logic       tick256,
  input  logic       tick1024,
  input  logic       wr_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       oc
);

  localparam logic [1:0] ADDR_TCNT  = 2'd0;
  localparam logic [1:0] ADDR_OCR   = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_FLAGS = 2'd3;

  // Writable CTRL bits; bit 7 is reserved, bit 5 (PWM) only exists in the PWM build.
`ifdef TIMER8_PWM_EN
  localparam logic [7:0] CTRL_MASK = 8'h7F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h5F;
`endif

  logic [7:0] r_tcnt;
  logic [7:0] r_ocr;
  logic [7:0] r_ctrl;
  logic       r_tov;
  logic       r_ocf;
  logic       r_oc;

  logic [2:0] w_cs;
  logic       w_ctc;
  logic       w_toie;
  logic       w_pwm;
  logic       w_ocie;
  logic       w_cnt_en;
  logic       w_tcnt_wr;
  logic       w_ocr_wr;
  logic       w_ctrl_wr;
  logic       w_flags_wr;
  logic       w_match;
  logic       w_top;
  logic       w_tov_set;
  logic       w_ocf_set;
  logic       w_tov_clr;
  logic       w_ocf_clr;
  logic [7:0] w_tcnt_next;
  logic       w_tov_next;
  logic       w_ocf_next;
  logic       w_oc_next;

  assign w_cs   = r_ctrl[2:0];
  assign w_ctc  = r_ctrl[3];
  assign w_toie = r_ctrl[4];
  assign w_pwm  = r_ctrl[5];
  assign w_ocie = r_ctrl[6];

  always_comb begin
    w_cnt_en = 1'b0;
    case (w_cs)
      3'd1:    w_cnt_en = 1'b1;
      3'd2:    w_cnt_en = tick8;
      3'd3:    w_cnt_en = tick64;
      3'd4:    w_cnt_en = tick256;
      3'd5:    w_cnt_en = tick1024;
      default: w_cnt_en = 1'b0;
    endcase
  end

  assign w_tcnt_wr  = wr_en && (addr == ADDR_TCNT);
  assign w_ocr_wr   = wr_en && (addr == ADDR_OCR);
  assign w_ctrl_wr  = wr_en && (addr == ADDR_CTRL);
  assign w_flags_wr = wr_en && (addr == ADDR_FLAGS);

  assign w_match = (r_tcnt == r_ocr);
  assign w_top   = (r_tcnt == 8'hFF);

  // A software TCNT write suppresses both the count and any flag event in that cycle.
  assign w_tov_set = w_cnt_en && !w_tcnt_wr && w_top;
  assign w_ocf_set = w_cnt_en && !w_tcnt_wr && w_match;

  assign w_tov_clr = w_flags_wr && wdata[0];
  assign w_ocf_clr = w_flags_wr && wdata[1];

  always_comb begin
    w_tcnt_next = r_tcnt;
    if (w_tcnt_wr) begin
      w_tcnt_next = wdata;
    end else if (w_cnt_en) begin
      if (w_ctc && w_match) begin
        w_tcnt_next = 8'h00;
      end else begin
        w_tcnt_next = r_tcnt + 8'd1;
      end
    end
  end

  // Hardware set has priority over a same-cycle W1C clear.
  assign w_tov_next = w_tov_set || (r_tov && !w_tov_clr);
  assign w_ocf_next = w_ocf_set || (r_ocf && !w_ocf_clr);

`ifdef TIMER8_PWM_EN
  assign w_oc_next = w_pwm && (r_tcnt < r_ocr);
`else
  assign w_oc_next = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tcnt <= 8'h00;
      r_ocr  <= OCR_RESET;
      r_ctrl <= 8'h00;
      r_tov  <= 1'b0;
      r_ocf  <= 1'b0;
      r_oc   <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_next;
      r_tov  <= w_tov_next;
      r_ocf  <= w_ocf_next;
      r_oc   <= w_oc_next;
      if (w_ocr_wr) begin
        r_ocr <= wdata;
      end
      if (w_ctrl_wr) begin
        r_ctrl <= wdata & CTRL_MASK;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      ADDR_TCNT:  rdata = r_tcnt;
      ADDR_OCR:   rdata = r_ocr;
      ADDR_CTRL:  rdata = r_ctrl;
      ADDR_FLAGS: rdata = {6'b000000, r_ocf, r_tov};
      default:    rdata = 8'h00;
    endcase
  end

  assign irq = (r_tov && w_toie) || (r_ocf && w_ocie);
  assign oc  = r_oc;

endmodule

// File: tb/tb_timer8_core.sv
// tb_timer8_core: directed scenarios plus random register/tick traffic, every cycle
// compared against a plain-arithmetic model of the timer.
module tb_timer8_core;

  localparam logic [7:0] P_OCR = 8'hC3;

  logic       clock;
  logic       reset;
  logic       tick8, tick64, tick256, tick1024;
  logic       wr_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;
  logic       oc;

  int total = 0;
  int bad   = 0;

  // model state
  int m_tcnt, m_ocr, m_ctrl, m_tov, m_ocf, m_oc;

  timer8_core #(.OCR_RESET(P_OCR)) dut (
    .clock(clock), .reset(reset),
    .tick8(tick8), .tick64(tick64), .tick256(tick256), .tick1024(tick1024),
    .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .oc(oc)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit wr, input int a, input int d, input bit [3:0] tk);
    int cs, en, twr, s_tov, s_ocf, n_tcnt, n_oc;
    if (rst) begin
      m_tcnt = 0; m_ocr = P_OCR; m_ctrl = 0; m_tov = 0; m_ocf = 0; m_oc = 0;
      return;
    end
    cs = m_ctrl % 8;
    en = (cs == 1) || (cs == 2 && tk[0]) || (cs == 3 && tk[1]) ||
         (cs == 4 && tk[2]) || (cs == 5 && tk[3]);
    twr = wr && (a == 0);
    s_tov = en && !twr && (m_tcnt == 255);
    s_ocf = en && !twr && (m_tcnt == m_ocr);
`ifdef TIMER8_PWM_EN
    n_oc = ((m_ctrl / 32) % 2 == 1) && (m_tcnt < m_ocr);
`else
    n_oc = 0;
`endif
    if (twr) n_tcnt = d;
    else if (en && (m_ctrl / 8) % 2 == 1 && m_tcnt == m_ocr) n_tcnt = 0;
    else if (en) n_tcnt = (m_tcnt + 1) % 256;
    else n_tcnt = m_tcnt;
    if (wr && a == 1) m_ocr = d;
    if (wr && a == 2) begin
      m_ctrl = d % 128;
`ifndef TIMER8_PWM_EN
      if ((m_ctrl / 32) % 2 == 1) m_ctrl = m_ctrl - 32;
`endif
    end
    if (wr && a == 3 && d % 2 == 1) m_tov = 0;
    if (wr && a == 3 && (d / 2) % 2 == 1) m_ocf = 0;
    if (s_tov != 0) m_tov = 1;
    if (s_ocf != 0) m_ocf = 1;
    m_tcnt = n_tcnt;
    m_oc = n_oc;
  endtask

  task automatic rd(input int a, output int v);
    addr = a[1:0];
    #1;
    v = int'(rdata);
  endtask

  task automatic check_all();
    int v;
    int m_irq;
    rd(0, v); check_val("tcnt", v, m_tcnt);
    rd(1, v); check_val("ocr", v, m_ocr);
    rd(2, v); check_val("ctrl", v, m_ctrl);
    rd(3, v); check_val("flags", v, m_ocf * 2 + m_tov);
    m_irq = ((m_tov == 1) && (m_ctrl / 16) % 2 == 1) || ((m_ocf == 1) && (m_ctrl / 64) % 2 == 1);
    check_val("irq", irq, m_irq);
    check_val("oc", oc, m_oc);
  endtask

  task automatic step(input bit rst, input bit wr, input int a, input int d, input bit [3:0] tk);
    reset = rst; wr_en = wr; addr = a[1:0]; wdata = d[7:0];
    {tick1024, tick256, tick64, tick8} = tk;
    @(posedge clock);
    model_edge(rst, wr, a, d, tk);
    #1;
    reset = 1'b0; wr_en = 1'b0; wdata = 8'h00;
    {tick1024, tick256, tick64, tick8} = 4'b0000;
    check_all();
  endtask

  task automatic wr(input int a, input int d);
    step(0, 1, a, d, 4'b0000);
  endtask

  task automatic idle(input bit [3:0] tk);
    step(0, 0, 0, 0, tk);
  endtask

  task automatic setup(input int ocr, input int tcnt);
    wr(2, 0); wr(1, ocr); wr(0, tcnt); wr(3, 8'hFF);
  endtask

  initial begin
    int v, hi, s;
    int seq_t[7];
    int seq_f[7];
    seq_t = '{1, 2, 3, 4, 0, 1, 2};
    seq_f = '{0, 0, 0, 0, 2, 2, 2};
    reset = 1'b1; wr_en = 1'b0; addr = 2'd0; wdata = 8'h00;
    {tick1024, tick256, tick64, tick8} = 4'b0000;

    // reset state
    step(1, 0, 0, 0, 4'b0000);
    rd(1, v); check_val("rst_ocr", v, P_OCR);
    check_val("rst_irq", irq, 0);

    // overflow with TOIE
    setup(8'h80, 0);
    wr(2, 8'h11);
    wr(0, 8'hFD);
    idle(0); idle(0); idle(0);
    rd(0, v); check_val("ovf_tcnt", v, 8'h00);
    rd(3, v); check_val("ovf_flags", v, 8'h01);
    check_val("ovf_irq", irq, 1);

    // TCNT write wins, then reset mid-count with a concurrent write
    wr(0, 8'h10);
    rd(0, v); check_val("wr_wins", v, 8'h10);
    idle(0); idle(0);
    step(1, 1, 1, 8'h55, 4'b0001);
    rd(0, v); check_val("mid_rst_tcnt", v, 0);
    rd(1, v); check_val("mid_rst_ocr", v, P_OCR);
    rd(2, v); check_val("mid_rst_ctrl", v, 0);

    // tick64 prescale, tick8 ignored
    setup(8'h80, 8'h20);
    wr(2, 8'h03);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 64; c++) begin
        idle({2'b00, c == 63, c % 8 == 7});
      end
      rd(0, v); check_val("pre64_tcnt", v, 8'h21 + p);
    end

    // CTC sequence with OCR=4
    setup(4, 0);
    wr(2, 8'h09);
    for (int i = 0; i < 7; i++) begin
      idle(0);
      rd(0, v); check_val("ctc_seq", v, seq_t[i]);
      rd(3, v); check_val("ctc_flags", v, seq_f[i]);
    end

    // CTC at OCR=FF sets both flags
    setup(8'hFF, 8'hFE);
    wr(2, 8'h09);
    idle(0); idle(0);
    rd(0, v); check_val("ctcff_tcnt", v, 0);
    rd(3, v); check_val("ctcff_flags", v, 3);

    // set beats W1C
    setup(8'h30, 8'h30);
    wr(2, 8'h02);
    idle(4'b0001);
    wr(0, 8'h30);
    step(0, 1, 3, 8'h02, 4'b0001);
    rd(3, v); check_val("w1c_hold", v, 2);
    step(0, 1, 3, 8'h02, 4'b0000);
    rd(3, v); check_val("w1c_clear", v, 0);

    // PWM duty (or forced low without the PWM build)
    setup(8'h40, 0);
    wr(2, 8'h21);
`ifdef TIMER8_PWM_EN
    s = 8'h21;
    hi = 64;
`else
    s = 8'h01;
    hi = 0;
`endif
    rd(2, v); check_val("pwm_ctrl", v, s);
    v = 0;
    for (int i = 0; i < 256; i++) begin
      idle(0);
      if (oc === 1'b1) v++;
    end
    check_val("pwm_duty", v, hi);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      bit [3:0] tk;
      for (int k = 0; k < 4; k++) tk[k] = ($urandom_range(3) == 0);
      step($urandom_range(299) == 0, $urandom_range(3) == 0,
           int'($urandom_range(3)), int'($urandom_range(255)), tk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
